// File: rtl/tmr_mismatch_monitor.sv
// Mismatch monitor for a bank of TMR voters: per-voter and global saturating
// event counters, primary/secondary LUT disagreement flag and a scrub request FSM.
module tmr_mismatch_monitor #(
    parameter int N_VOTERS = 16,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_VOTERS-1:0] mismatch_i,
    input  logic [N_VOTERS-1:0] mismatch_2nd_i,
    input  logic                clear_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                rd_valid_o,
    output logic [CNT_W-1:0]    total_cnt_o,
    output logic                any_mismatch_o,
    output logic                disagree_o,
    output logic                refresh_req_o,
    input  logic                refresh_ack_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [N_VOTERS-1:0] m_q, m2_q, m_qq, evt_q;
    logic                any_q, disagree_q, rd_valid_q, req_q;
    logic                pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q [N_VOTERS];
    logic [CNT_W-1:0]    total_q, rd_data_q, rd_mux_s;
    logic                new_evt_s;
    state_t              state_q, state_d;

    assign new_evt_s = |evt_q;

    // Input capture and rising-edge event detection; evt is registered so
    // counters and the FSM see an event two edges after the input rises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q   <= '0;
            m2_q  <= '0;
            m_qq  <= '0;
            evt_q <= '0;
            any_q <= 1'b0;
        end else begin
            m_q   <= mismatch_i;
            m2_q  <= mismatch_2nd_i;
            m_qq  <= m_q;
            evt_q <= m_q & ~m_qq;
            any_q <= |m_q;
        end
    end

    // Per-voter counters, event total and sticky disagreement; clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int k = 0; k < N_VOTERS; k++) cnt_q[k] <= '0;
            total_q    <= '0;
            disagree_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_VOTERS; k++) begin
                if (evt_q[k]) cnt_q[k] <= sat_inc(cnt_q[k]);
                else          cnt_q[k] <= cnt_q[k];
            end
            total_q    <= new_evt_s ? sat_inc(total_q) : total_q;
            disagree_q <= disagree_q | (|(m_q ^ m2_q));
        end
    end

    // Read mux; addresses with no voter behind them fall through to zero.
    always_comb begin
        rd_mux_s = '0;
        for (int k = 0; k < N_VOTERS; k++) begin
            rd_mux_s = (rd_addr_i == ADDR_W'(k)) ? cnt_q[k] : rd_mux_s;
        end
    end

    // Read port register; data holds between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            rd_data_q  <= rd_en_i ? rd_mux_s : rd_data_q;
        end
    end

    // Scrub FSM next-state; pending only remembers events seen in HOLDOFF.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (new_evt_s) state_d = REQ;
                else           state_d = IDLE;
            end
            REQ: begin
                if (refresh_ack_i) state_d = HOLDOFF;
                else               state_d = REQ;
            end
            HOLDOFF: begin
                if (!(|m_q)) begin
                    state_d   = (pending_q || new_evt_s) ? REQ : IDLE;
                    pending_d = 1'b0;
                end else if (new_evt_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Scrub FSM state and registered request output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= (state_d == REQ);
        end
    end

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign total_cnt_o    = total_q;
    assign any_mismatch_o = any_q;
    assign disagree_o     = disagree_q;
    assign refresh_req_o  = req_q;

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// Directed bench for tmr_mismatch_monitor (10 voters, 4-bit counters).
module tb_tmr_mismatch_monitor;

    localparam int NV = 10;
    localparam int CW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, clear, rd_en, ack;
    logic [NV-1:0] mis, mis2;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data, total;
    logic          rd_valid, any_mis, disagree, req;

    int n_cmp = 0;
    int n_bad = 0;

    tmr_mismatch_monitor #(.N_VOTERS(NV), .CNT_W(CW), .ADDR_W(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mismatch_i     (mis),
        .mismatch_2nd_i (mis2),
        .clear_i        (clear),
        .rd_en_i        (rd_en),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .total_cnt_o    (total),
        .any_mismatch_o (any_mis),
        .disagree_o     (disagree),
        .refresh_req_o  (req),
        .refresh_ack_i  (ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input int addr, input int exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
        chk_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk_eq({tag, "_data"}, 32'(rd_data), exp);
        tick();
        chk_eq({tag, "_vlow"}, 32'(rd_valid), 32'd0);
        chk_eq({tag, "_hold"}, 32'(rd_data), exp);
    endtask

    task automatic settle();
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
    endtask

    task automatic count_rises(input int cycles, output int rises, output logic last);
        logic prev;
        prev  = req;
        rises = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (req && !prev) rises++;
            prev = req;
        end
        last = req;
    endtask

    int   rises;
    logic last;

    initial begin
        rst = 1'b1; clear = 1'b0; rd_en = 1'b0; ack = 1'b0;
        mis = '0; mis2 = '0; rd_addr = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk_eq("rst_total", 32'(total), 32'd0);
        chk_eq("rst_req", 32'(req), 32'd0);
        chk_eq("rst_any", 32'(any_mis), 32'd0);
        chk_eq("rst_valid", 32'(rd_valid), 32'd0);
        chk_eq("rst_data", 32'(rd_data), 32'd0);

        // voter 3 held 10 cycles, three times: counted once per rise
        for (int r = 0; r < 3; r++) begin
            mis[3] = 1'b1;
            tick();
            if (r == 0) chk_eq("any_early", 32'(any_mis), 32'd0);
            tick();
            if (r == 0) chk_eq("any_2cyc", 32'(any_mis), 32'd1);
            repeat (8) tick();
            mis[3] = 1'b0;
            repeat (3) tick();
        end
        chk_eq("t1_total", 32'(total), 32'd3);
        rd_chk(3, 3, "t1_cnt3");
        rd_chk(0, 0, "t1_cnt0");
        rd_chk(12, 0, "t1_oor");
        settle();

        // saturation on voter 0 with 20 single-cycle pulses
        for (int r = 0; r < 20; r++) begin
            mis[0] = 1'b1;
            tick();
            mis[0] = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk_eq("sat_total", 32'(total), 32'd15);
        rd_chk(0, 15, "sat_cnt0");
        settle();

        // simultaneous rise on 1 and 5; request timing and holdoff
        mis[1] = 1'b1; mis[5] = 1'b1;
        tick();
        chk_eq("t3_req_e0", 32'(req), 32'd0);
        tick();
        chk_eq("t3_req_e1", 32'(req), 32'd0);
        tick();
        chk_eq("t3_req_e2", 32'(req), 32'd1);
        chk_eq("t3_total", 32'(total), 32'd1);
        repeat (2) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_eq("t3_req_ack", 32'(req), 32'd0);
        count_rises(4, rises, last);
        chk_eq("t3_hold_rises", 32'(rises), 32'd0);
        mis[1] = 1'b0; mis[5] = 1'b0;
        count_rises(5, rises, last);
        chk_eq("t3_idle_rises", 32'(rises), 32'd0);
        rd_chk(1, 1, "t3_cnt1");
        rd_chk(5, 1, "t3_cnt5");
        settle();

        // event during HOLDOFF is remembered and re-requests once
        mis[2] = 1'b1;
        repeat (3) tick();
        chk_eq("t4_req", 32'(req), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        mis[7] = 1'b1;
        tick();
        mis[7] = 1'b0;
        repeat (3) tick();
        chk_eq("t4_req_hold", 32'(req), 32'd0);
        mis[2] = 1'b0;
        count_rises(6, rises, last);
        chk_eq("t4_rises", 32'(rises), 32'd1);
        chk_eq("t4_req_last", 32'(last), 32'd1);
        chk_eq("t4_total", 32'(total), 32'd2);
        settle();

        // same without the pulse: back to IDLE, no request
        mis[2] = 1'b1;
        repeat (3) tick();
        chk_eq("t4b_req", 32'(req), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (3) tick();
        mis[2] = 1'b0;
        count_rises(6, rises, last);
        chk_eq("t4b_rises", 32'(rises), 32'd0);
        chk_eq("t4b_req_last", 32'(last), 32'd0);
        settle();

        // disagreement sticky, then clear racing a new event
        chk_eq("t5_dis0", 32'(disagree), 32'd0);
        mis[4] = 1'b1;
        tick();
        mis[4] = 1'b0;
        tick();
        chk_eq("t5_dis_set", 32'(disagree), 32'd1);
        repeat (4) tick();
        chk_eq("t5_dis_sticky", 32'(disagree), 32'd1);
        rd_chk(4, 1, "t5_cnt4");
        mis[4] = 1'b1; mis2[4] = 1'b1;
        repeat (2) tick();
        clear = 1'b1; rd_en = 1'b1; rd_addr = AW'(4);
        tick();
        clear = 1'b0; rd_en = 1'b0;
        chk_eq("t5_rd_preclr", 32'(rd_data), 32'd1);
        chk_eq("t5_total_clr", 32'(total), 32'd0);
        chk_eq("t5_dis_clr", 32'(disagree), 32'd0);
        repeat (4) tick();
        chk_eq("t5_total_held", 32'(total), 32'd0);
        rd_chk(4, 0, "t5_cnt4_clr");

        // reset with request up and counters non-zero; late ack ignored
        mis[6] = 1'b1;
        repeat (3) tick();
        chk_eq("t6_total_pre", 32'(total), 32'd1);
        chk_eq("t6_req_pre", 32'(req), 32'd1);
        chk_eq("t6_dis_pre", 32'(disagree), 32'd1);
        rd_chk(6, 1, "t6_cnt6");
        rst = 1'b1; mis = '0; mis2 = '0;
        tick();
        rst = 1'b0;
        chk_eq("t6_total", 32'(total), 32'd0);
        chk_eq("t6_req", 32'(req), 32'd0);
        chk_eq("t6_any", 32'(any_mis), 32'd0);
        chk_eq("t6_dis", 32'(disagree), 32'd0);
        chk_eq("t6_data", 32'(rd_data), 32'd0);
        chk_eq("t6_valid", 32'(rd_valid), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        count_rises(4, rises, last);
        chk_eq("t6_late_ack", 32'(rises), 32'd0);
        rd_chk(6, 0, "t6_cnt6_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
